// File: rtl/instr_fetch_unit_pkg.sv
// ifu_pkg: shared widths and assembler state encoding for the instruction fetch unit
package ifu_pkg;
  localparam int INSTR_W = 16;
  localparam int BYTE_W = 8;
  typedef enum logic {ASM_LO = 1'b0, ASM_HI = 1'b1} asm_state_e;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: byte-side and instruction-side handshakes of the fetch unit
interface instr_fetch_unit_if;
  import ifu_pkg::*;
  logic [BYTE_W-1:0] byte_in;
  logic byte_valid;
  logic byte_ready;
  logic [INSTR_W-1:0] instr_out;
  logic instr_valid;
  logic instr_ready;
  modport slave(input byte_in, byte_valid, instr_ready, output byte_ready, instr_out, instr_valid);
  modport master(output byte_in, byte_valid, instr_ready, input byte_ready, instr_out, instr_valid);
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// sync_fifo: show-ahead FIFO with synchronous flush and wrapping pointers
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push && !flush) mem_d[wr_q] = din;
    wr_d = flush ? '0 : push ? wr_q + PW'(1) : wr_q;
    rd_d = flush ? '0 : pop ? rd_q + PW'(1) : rd_q;
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  assign dout = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: pairs pad bytes (low first) into 16-bit words and queues them for the control block
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   flush,
  instr_fetch_unit_if.slave      bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);
  localparam int CW = $clog2(DEPTH) + 1;
  asm_state_e state_q, state_d;
  logic [BYTE_W-1:0] lo_hold_q, lo_hold_d;
  logic overflow_q, overflow_d;
  logic accept, push, pop;
  // Ready looks only at registered count, so a pop never frees space for a same-cycle push
  always_comb begin
    bus.byte_ready = rst_n & ena & ((state_q == ASM_LO) | (fifo_count < CW'(DEPTH)));
    bus.instr_valid = ena & (fifo_count != '0);
    accept = bus.byte_valid & bus.byte_ready;
    push = accept & (state_q == ASM_HI) & ~flush;
    pop = bus.instr_valid & bus.instr_ready & ~flush;
    state_d = flush ? ASM_LO : accept ? ((state_q == ASM_LO) ? ASM_HI : ASM_LO) : state_q;
    lo_hold_d = (accept & (state_q == ASM_LO) & ~flush) ? bus.byte_in : lo_hold_q;
    overflow_d = flush ? 1'b0 : overflow_q | (ena & bus.byte_valid & ~bus.byte_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ASM_LO;
      lo_hold_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_hold_q <= lo_hold_d;
      overflow_q <= overflow_d;
    end
  end
  sync_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .push(push),
    .pop(pop),
    .din({bus.byte_in, lo_hold_q}),
    .dout(bus.instr_out),
    .count(fifo_count)
  );
  assign overflow = overflow_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table plus hand-written corner sequences
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic flush = 1'b0;
  logic [2:0] fifo_count;
  logic overflow;
  int n_chk = 0;
  int n_fail = 0;
  instr_fetch_unit_if bus();
  instr_fetch_unit #(.DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .flush(flush),
    .bus(bus.slave),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic en, bv;
    logic [7:0] b;
    logic ir, fl;
    logic [2:0] cnt;
    logic iv;
    logic [15:0] out;
    logic ovf, br;
  } vec_t;
  vec_t tbl[18];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic en, input logic bv, input logic [7:0] b, input logic ir, input logic fl);
    @(negedge clk);
    ena = en;
    bus.byte_valid = bv;
    bus.byte_in = b;
    bus.instr_ready = ir;
    flush = fl;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int k;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    bus.instr_ready = 1'b0;
    // ena,bv,byte,ir,flush | count,valid,out,overflow,byte_ready after the edge
    tbl[0]  = '{1, 1, 8'h34, 1, 0, 3'd0, 0, 16'h0000, 0, 1};
    tbl[1]  = '{1, 1, 8'h12, 1, 0, 3'd1, 1, 16'h1234, 0, 1};
    tbl[2]  = '{1, 0, 8'h00, 1, 0, 3'd0, 0, 16'h0000, 0, 1};
    tbl[3]  = '{1, 1, 8'h01, 0, 0, 3'd0, 0, 16'h0000, 0, 1};
    tbl[4]  = '{1, 1, 8'h02, 0, 0, 3'd1, 1, 16'h0201, 0, 1};
    tbl[5]  = '{1, 1, 8'h03, 0, 0, 3'd1, 1, 16'h0201, 0, 1};
    tbl[6]  = '{1, 1, 8'h04, 0, 0, 3'd2, 1, 16'h0201, 0, 1};
    tbl[7]  = '{1, 1, 8'h05, 0, 0, 3'd2, 1, 16'h0201, 0, 1};
    tbl[8]  = '{1, 1, 8'h06, 0, 0, 3'd3, 1, 16'h0201, 0, 1};
    tbl[9]  = '{1, 1, 8'h07, 0, 0, 3'd3, 1, 16'h0201, 0, 1};
    tbl[10] = '{1, 1, 8'h08, 0, 0, 3'd4, 1, 16'h0201, 0, 1};
    tbl[11] = '{1, 1, 8'h09, 0, 0, 3'd4, 1, 16'h0201, 0, 0};
    tbl[12] = '{1, 1, 8'h0A, 0, 0, 3'd4, 1, 16'h0201, 1, 0};
    tbl[13] = '{1, 0, 8'h00, 1, 0, 3'd3, 1, 16'h0403, 1, 1};
    tbl[14] = '{1, 0, 8'h00, 1, 0, 3'd2, 1, 16'h0605, 1, 1};
    tbl[15] = '{1, 0, 8'h00, 1, 0, 3'd1, 1, 16'h0807, 1, 1};
    tbl[16] = '{1, 0, 8'h00, 1, 0, 3'd0, 0, 16'h0000, 1, 1};
    tbl[17] = '{1, 1, 8'hEE, 1, 1, 3'd0, 0, 16'h0000, 0, 1};
    #12;
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_out", bus.instr_out, 16'h0000);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", bus.byte_ready, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].en, tbl[i].bv, tbl[i].b, tbl[i].ir, tbl[i].fl);
      chk($sformatf("v%0d_count", i), fifo_count, tbl[i].cnt);
      chk($sformatf("v%0d_valid", i), bus.instr_valid, tbl[i].iv);
      chk($sformatf("v%0d_ovf", i), overflow, tbl[i].ovf);
      chk($sformatf("v%0d_ready", i), bus.byte_ready, tbl[i].br);
      if (tbl[i].iv) chk($sformatf("v%0d_out", i), bus.instr_out, tbl[i].out);
    end
    k = 0;
    for (int i = 0; i < 16; i++) begin
      for (int h = 0; h < 2; h++) begin
        cyc(1, 1, (h == 0) ? 8'(i) : 8'h01, 1, 0);
        chk("t3_count_le1", fifo_count <= 3'd1, 1);
        if (bus.instr_valid) begin
          chk($sformatf("t3_word%0d", k), bus.instr_out, 16'h0100 + 16'(k));
          k++;
        end
      end
    end
    cyc(1, 0, 8'h00, 1, 0);
    chk("t3_words_seen", k, 16);
    chk("t3_count_end", fifo_count, 0);
    cyc(1, 1, 8'hAA, 1, 0);
    cyc(1, 0, 8'h00, 1, 1);
    cyc(1, 1, 8'h11, 1, 0);
    cyc(1, 1, 8'h22, 1, 0);
    chk("t4_valid", bus.instr_valid, 1);
    chk("t4_out", bus.instr_out, 16'h2211);
    chk("t4_ovf", overflow, 0);
    cyc(1, 0, 8'h00, 1, 0);
    chk("t4_count", fifo_count, 0);
    cyc(1, 1, 8'h77, 0, 0);
    cyc(1, 1, 8'h66, 0, 0);
    chk("t5_pre_count", fifo_count, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 8'h99, 1, 0);
      chk("t5_hold_count", fifo_count, 1);
      chk("t5_hold_valid", bus.instr_valid, 0);
      chk("t5_hold_ready", bus.byte_ready, 0);
      chk("t5_hold_ovf", overflow, 0);
    end
    @(negedge clk);
    ena = 1'b1;
    bus.byte_valid = 1'b0;
    bus.instr_ready = 1'b1;
    #1;
    chk("t5_resume_valid", bus.instr_valid, 1);
    chk("t5_resume_out", bus.instr_out, 16'h6677);
    @(posedge clk);
    #1;
    chk("t5_resume_pop", fifo_count, 0);
    cyc(1, 1, 8'h03, 0, 0);
    cyc(1, 1, 8'h04, 0, 0);
    chk("t5_next_out", bus.instr_out, 16'h0403);
    cyc(1, 1, 8'h55, 0, 0);
    chk("t6_pre_count", fifo_count, 1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", bus.instr_valid, 0);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_ready", bus.byte_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 1, 8'h01, 1, 0);
    chk("t6_lo_only", bus.instr_valid, 0);
    cyc(1, 1, 8'h02, 1, 0);
    chk("t6_valid", bus.instr_valid, 1);
    chk("t6_out", bus.instr_out, 16'h0201);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
